masked_sbox_scheduler: RTL and testbench



---
 rtl/masked_sbox_scheduler.sv | 143 ++++++++++++++
 tb/tb_masked_sbox_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/masked_sbox_scheduler.sv
// Sequences one 16-byte masked AES state through a pool of pipelined masked inverters.
// Bytes are issued NUM_SBOX per cycle, tagged, written back in place, then handed on.
module masked_sbox_scheduler #(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned NUM_SBOX   = 4,
  parameter int unsigned LATENCY    = 3
) (
  input  logic                             in_clock,
  input  logic                             in_reset,
  input  logic                             in_start_valid,
  output logic                             out_start_ready,
  input  logic [16*NUM_SHARES*8-1:0]       in_state,
  output logic [NUM_SBOX*NUM_SHARES*8-1:0] out_sbox_a,
  output logic                             out_sbox_issue,
  input  logic [NUM_SBOX*NUM_SHARES*8-1:0] in_sbox_b,
  output logic                             out_rand_en,
  output logic                             out_done_valid,
  input  logic                             in_done_ready,
  output logic [16*NUM_SHARES*8-1:0]       out_state,
  output logic                             out_busy
);

  localparam int unsigned BW    = NUM_SHARES * 8;
  localparam int unsigned BEATS = (NUM_SBOX == 0) ? 1 : 16 / NUM_SBOX;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((NUM_SBOX == 0) || ((16 % NUM_SBOX) != 0)) begin : g_bad_num_sbox
    $error("masked_sbox_scheduler: NUM_SBOX must divide 16");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("masked_sbox_scheduler: LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic             vld;
    logic [CNT_W-1:0] beat;
  } tag_t;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic [16*BW-1:0]        buf_q, buf_d;
  tag_t [LATENCY-1:0]      tag_q, tag_d;
  tag_t                    tail;
  logic                    start_ready_q, start_ready_d;
  logic                    done_valid_q, done_valid_d;
  logic                    rand_en_q, rand_en_d;
  logic                    busy_q, busy_d;

  assign tail = tag_q[LATENCY-1];

  // Next state, beat issue, tag shift and in-place writeback.
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    buf_d          = buf_q;
    out_sbox_a     = '0;
    out_sbox_issue = 1'b0;
    tag_d[0]       = '0;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (in_start_valid) begin
          buf_d   = in_state;
          beat_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        out_sbox_issue = 1'b1;
        for (int unsigned k = 0; k < NUM_SBOX; k++) begin
          out_sbox_a[k*BW +: BW] = buf_q[(int'(beat_q)*NUM_SBOX + k)*BW +: BW];
        end
        tag_d[0] = '{vld: 1'b1, beat: beat_q};
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = S_DRAIN;
        end else begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (tail.vld && (tail.beat == LAST_BEAT)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (in_done_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Each share of each returned byte lands back in its own slot.
    if (tail.vld) begin
      for (int unsigned k = 0; k < NUM_SBOX; k++) begin
        for (int unsigned s = 0; s < NUM_SHARES; s++) begin
          buf_d[(int'(tail.beat)*NUM_SBOX + k)*BW + s*8 +: 8] = in_sbox_b[k*BW + s*8 +: 8];
        end
      end
    end

    start_ready_d = (state_d == S_IDLE);
    done_valid_d  = (state_d == S_DONE);
    rand_en_d     = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      buf_q         <= '0;
      tag_q         <= '0;
      start_ready_q <= 1'b1;
      done_valid_q  <= 1'b0;
      rand_en_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      buf_q         <= buf_d;
      tag_q         <= tag_d;
      start_ready_q <= start_ready_d;
      done_valid_q  <= done_valid_d;
      rand_en_q     <= rand_en_d;
      busy_q        <= busy_d;
    end
  end

  assign out_start_ready = start_ready_q;
  assign out_done_valid  = done_valid_q;
  assign out_rand_en     = rand_en_q;
  assign out_busy        = busy_q;
  assign out_state       = buf_q;

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
// Bench for masked_sbox_scheduler: default pool (4 slots) plus an 8-slot instance,
// each fed by a 3-stage behavioural inverter pipe; results checked via scoreboard queues.
module tb_masked_sbox_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0, start_ready, issue, rand_en, done_valid, done_ready = 1'b0, busy;
  logic [255:0] st_in = '0, st_out;
  logic [63:0]  sbox_a, sbox_b;
  logic         start_valid8 = 1'b0, start_ready8, issue8, rand_en8, done_valid8, done_ready8 = 1'b0, busy8;
  logic [255:0] st_in8 = '0, st_out8;
  logic [127:0] sbox_a8, sbox_b8;

  int n_checks = 0;
  int n_fail   = 0;
  logic [255:0] exp_q[$];
  logic [255:0] exp8_q[$];

  masked_sbox_scheduler u_dut (
    .in_clock(clk), .in_reset(rst_n), .in_start_valid(start_valid), .out_start_ready(start_ready),
    .in_state(st_in), .out_sbox_a(sbox_a), .out_sbox_issue(issue), .in_sbox_b(sbox_b),
    .out_rand_en(rand_en), .out_done_valid(done_valid), .in_done_ready(done_ready),
    .out_state(st_out), .out_busy(busy)
  );

  masked_sbox_scheduler #(.NUM_SHARES(2), .NUM_SBOX(8), .LATENCY(3)) u_dut8 (
    .in_clock(clk), .in_reset(rst_n), .in_start_valid(start_valid8), .out_start_ready(start_ready8),
    .in_state(st_in8), .out_sbox_a(sbox_a8), .out_sbox_issue(issue8), .in_sbox_b(sbox_b8),
    .out_rand_en(rand_en8), .out_done_valid(done_valid8), .in_done_ready(done_ready8),
    .out_state(st_out8), .out_busy(busy8)
  );

  // Behavioural inverter pools: 3 register stages each.
  function automatic logic [127:0] f8(input logic [127:0] a);
    logic [127:0] r = a;
    for (int k = 0; k < 8; k++) r[k*16 +: 8] = a[k*16 +: 8] ^ 8'(k + 1);
    return r;
  endfunction

  logic [63:0]  p1 = '0, p2 = '0, p3 = '0;
  logic [127:0] q1 = '0, q2 = '0, q3 = '0;
  always @(posedge clk) begin
    p1 <= sbox_a ^ {4{16'h00FF}};
    p2 <= p1;
    p3 <= p2;
    q1 <= f8(sbox_a8);
    q2 <= q1;
    q3 <= q2;
  end
  assign sbox_b  = p3;
  assign sbox_b8 = q3;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks += 6;
    if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready: got %b expected 1", start_ready); end
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_done_valid: got %b expected 0", done_valid); end
    if (st_out !== '0)        begin n_fail++; $display("FAIL reset_state: got %h expected 0", st_out); end
    if (rand_en !== 1'b0 || issue !== 1'b0) begin n_fail++; $display("FAIL reset_rand_issue: got %b%b expected 00", rand_en, issue); end
    if (st_out8 !== '0 || start_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_dut8: got %h/%b expected 0/1", st_out8, start_ready8); end
  endtask

  // One pass on the default instance, ending in DONE with the result checked.
  task automatic run_pass(input logic [255:0] st, input logic [255:0] exp);
    int n = 0, n_issue = 0, n_rand = 0;
    logic [255:0] e;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    st_in = st; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    while (done_valid !== 1'b1 && n < 30) begin
      if (issue === 1'b1) n_issue++;
      if (rand_en === 1'b1) n_rand++;
      @(posedge clk); #1;
      n++;
    end
    e = exp_q.pop_front();
    n_checks += 6;
    if (n !== 7)       begin n_fail++; $display("FAIL pass_latency: got %0d edges expected 7", n); end
    if (n_issue !== 4) begin n_fail++; $display("FAIL pass_issue_cycles: got %0d expected 4", n_issue); end
    if (n_rand !== 7)  begin n_fail++; $display("FAIL pass_rand_cycles: got %0d expected 7", n_rand); end
    if (st_out !== e)  begin n_fail++; $display("FAIL pass_result: got %h expected %h", st_out, e); end
    if (rand_en !== 1'b0 || start_ready !== 1'b0) begin n_fail++; $display("FAIL pass_done_flags: rand_en %b start_ready %b expected 0 0", rand_en, start_ready); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL pass_done_busy: got %b expected 1", busy); end
  endtask

  task automatic release_done(input logic [255:0] exp);
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    n_checks += 4;
    if (done_valid !== 1'b0)  begin n_fail++; $display("FAIL release_done_valid: got %b expected 0", done_valid); end
    if (start_ready !== 1'b1) begin n_fail++; $display("FAIL release_start_ready: got %b expected 1", start_ready); end
    if (busy !== 1'b0 || rand_en !== 1'b0) begin n_fail++; $display("FAIL release_idle: busy %b rand_en %b expected 0 0", busy, rand_en); end
    if (st_out !== exp)       begin n_fail++; $display("FAIL release_state: got %h expected %h", st_out, exp); end
  endtask

  task automatic test_single_pass();
    logic [255:0] st = '0, exp = '0;
    for (int i = 0; i < 16; i++) begin
      st[i*16 +: 8]  = 8'(i);
      exp[i*16 +: 8] = 8'(i) ^ 8'hFF;
    end
    run_pass(st, exp);
    release_done(exp);
  endtask

  task automatic test_backpressure();
    logic [255:0] st = '0, exp = '0, st2 = '0, exp2 = '0;
    for (int i = 0; i < 16; i++) begin
      st[i*16 +: 16]   = 16'($urandom);
      exp[i*16 +: 16]  = st[i*16 +: 16] ^ 16'h00FF;
      st2[i*16 +: 16]  = 16'($urandom);
      exp2[i*16 +: 16] = st2[i*16 +: 16] ^ 16'h00FF;
    end
    run_pass(st, exp);
    for (int c = 0; c < 10; c++) begin
      n_checks += 3;
      if (done_valid !== 1'b1)  begin n_fail++; $display("FAIL bp_done_valid c%0d: got %b expected 1", c, done_valid); end
      if (st_out !== exp)       begin n_fail++; $display("FAIL bp_state c%0d: got %h expected %h", c, st_out, exp); end
      if (start_ready !== 1'b0) begin n_fail++; $display("FAIL bp_start_ready c%0d: got %b expected 0", c, start_ready); end
      if (c == 4) begin st_in = ~st; start_valid = 1'b1; end
      if (c == 5) start_valid = 1'b0;
      @(posedge clk); #1;
    end
    release_done(exp);
    run_pass(st2, exp2);
    release_done(exp2);
  endtask

  task automatic test_slot_map();
    logic [255:0] st = '0, exp = '0, e;
    int n = 1;
    for (int i = 0; i < 16; i++) begin
      st[i*16 +: 8]      = 8'(i + 16);
      st[i*16 + 8 +: 8]  = 8'(i + 160);
      exp[i*16 +: 8]     = 8'(i + 16) ^ 8'((i % 8) + 1);
      exp[i*16 + 8 +: 8] = 8'(i + 160);
    end
    exp8_q.push_back(exp);
    @(posedge clk); #1;
    st_in8 = st; start_valid8 = 1'b1;
    @(posedge clk); #1;
    start_valid8 = 1'b0;
    @(posedge clk); #1;
    n_checks += 2;
    if (sbox_a8[3*16 +: 16] !== st[11*16 +: 16]) begin n_fail++; $display("FAIL slot_b1_k3: got %h expected %h", sbox_a8[3*16 +: 16], st[11*16 +: 16]); end
    if (sbox_a8 !== st[255:128] || issue8 !== 1'b1) begin n_fail++; $display("FAIL slot_beat1_all: got %h/%b expected %h/1", sbox_a8, issue8, st[255:128]); end
    while (done_valid8 !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    e = exp8_q.pop_front();
    n_checks += 3;
    if (n !== 5)        begin n_fail++; $display("FAIL slot_latency: got %0d edges expected 5", n); end
    if (st_out8 !== e)  begin n_fail++; $display("FAIL slot_result: got %h expected %h", st_out8, e); end
    if (st_out8[11*16 +: 16] !== e[11*16 +: 16]) begin n_fail++; $display("FAIL slot_byte11: got %h expected %h", st_out8[11*16 +: 16], e[11*16 +: 16]); end
    done_ready8 = 1'b1;
    @(posedge clk); #1;
    done_ready8 = 1'b0;
    n_checks += 1;
    if (done_valid8 !== 1'b0 || start_ready8 !== 1'b1) begin n_fail++; $display("FAIL slot_release: got %b%b expected 01", done_valid8, start_ready8); end
  endtask

  task automatic test_mid_reset();
    logic [255:0] st = '0, exp = '0;
    for (int i = 0; i < 16; i++) begin
      st[i*16 +: 16]  = 16'($urandom);
      exp[i*16 +: 16] = st[i*16 +: 16] ^ 16'h00FF;
    end
    @(posedge clk); #1;
    st_in = ~st; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (issue !== 1'b0 || sbox_a !== '0) begin n_fail++; $display("FAIL midrst_issue: got %b/%h expected 0/0", issue, sbox_a); end
    if (rand_en !== 1'b0 || busy !== 1'b0 || done_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: rand %b busy %b done %b expected 000", rand_en, busy, done_valid); end
    if (start_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_start_ready: got %b expected 1", start_ready); end
    if (st_out !== '0)        begin n_fail++; $display("FAIL midrst_state: got %h expected 0", st_out); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_pass(st, exp);
    release_done(exp);
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_backpressure();
    test_slot_map();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
